// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-port data-memory arbiter. Port 0 is the core load/store unit and
// port 1 is the program loader. Both share one synchronous single-port
// memory (read data returns one cycle after the access strobe).
//
// Ownership is tracked by a three-state FSM (IDLE, OWN0, OWN1). A grant is
// issued combinationally whenever the current owner is requesting. A beat
// counter bounds how long one owner keeps the memory while the other port
// is waiting.
//
// Configuration macro: ARB_RR_EN
//   defined   : ties in IDLE go to the port that did not own the last grant,
//               and both owners can be preempted after MAX_BURST beats.
//   undefined : fixed priority, port 0 wins ties and is never preempted;
//               port 1 is preempted after MAX_BURST beats when port 0 waits.
//
// Parameters
//   ADDR_W     address width of the memory and both requesters
//   DATA_W     data width of the memory and both requesters
//   MAX_BURST  beats granted to one owner while the other port requests
//
// Ports
//   clk                  clock, rising edge
//   rst_n                asynchronous reset, active HIGH despite the name
//   req0/req1            access request
//   we0/we1              1 = write, 0 = read
//   addr0/addr1          byte address
//   wdata0/wdata1        write data
//   gnt0/gnt1            access issued to memory this cycle
//   rvalid0/rvalid1      read data valid this cycle
//   rdata0/rdata1        read data (zero when rvalid is low)
//   mem_en/mem_we        memory strobe / write enable
//   mem_addr/mem_wdata   memory address / write data (zero when idle)
//   mem_rdata            memory read data, one cycle after a read strobe
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Counter wide enough to hold MAX_BURST-1 (at least one bit).
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

`ifdef ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             last_owner_r;
    logic             rvalid0_r;
    logic             rvalid1_r;
    logic             cnt_at_max_s;
    logic             tie_pick1_s;
    logic             any_gnt_s;

    // Grants are a pure function of ownership and the owner's request.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_r == OWN0) begin
            gnt0 = req0;
        end else if (state_r == OWN1) begin
            gnt1 = req1;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign any_gnt_s    = gnt0 | gnt1;
    assign cnt_at_max_s = (cnt_r == CNT_MAX);

    // Tie-break in IDLE: round-robin picks the port that did not own the
    // last grant; fixed priority always picks port 0.
    always_comb begin
        tie_pick1_s = 1'b0;
        if (RR_EN) begin
            tie_pick1_s = (last_owner_r == 1'b0);
        end else begin
            tie_pick1_s = 1'b0;
        end
    end

    // Next-state logic: entry from IDLE, release on dropped request, and
    // burst-limit preemption with a direct owner-to-owner handover.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt_s = tie_pick1_s ? OWN1 : OWN0;
                end else if (req0) begin
                    state_nxt_s = OWN0;
                end else if (req1) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_nxt_s = req1 ? OWN1 : IDLE;
                end else if (RR_EN && cnt_at_max_s && req1) begin
                    // Port 0 is only preemptible in round-robin mode.
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = OWN0;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_nxt_s = req0 ? OWN0 : IDLE;
                end else if (cnt_at_max_s && req0) begin
                    state_nxt_s = OWN0;
                end else begin
                    state_nxt_s = OWN1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Beat counter: cleared on any ownership change, counts granted beats
    // and saturates at MAX_BURST-1 while the other port is quiet.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (any_gnt_s && !cnt_at_max_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Memory-side mux: driven from the granted port, all zero when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (gnt0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end else begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // FSM state, beat counter and last-owner record.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            last_owner_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (gnt0) begin
                last_owner_r <= 1'b0;
            end else if (gnt1) begin
                last_owner_r <= 1'b1;
            end else begin
                last_owner_r <= last_owner_r;
            end
        end
    end

    // Read-return tracking: a granted read flags its port for exactly one
    // cycle, matching the one-cycle memory latency. Reset kills any read
    // still in flight.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            rvalid0_r <= gnt0 & ~we0;
            rvalid1_r <= gnt1 & ~we1;
        end
    end

    assign rvalid0 = rvalid0_r;
    assign rvalid1 = rvalid1_r;

    // Return data is steered to the waiting port only; zero otherwise.
    always_comb begin
        rdata0 = {DATA_W{1'b0}};
        rdata1 = {DATA_W{1'b0}};
        if (rvalid0_r) begin
            rdata0 = mem_rdata;
        end else begin
            rdata0 = {DATA_W{1'b0}};
        end
        if (rvalid1_r) begin
            rdata1 = mem_rdata;
        end else begin
            rdata1 = {DATA_W{1'b0}};
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width of the memory and both requesters.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width of the memory and both requesters.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, meaning the maximum number of consecutive beats granted to one owner while the other port is requesting.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-high (asserted = 1).
REQ-006 req0 / req1  input  1  access request: port 0 = core load/store, port 1 = program loader.
REQ-007 we0 / we1  input  1  1 = write, 0 = read.
REQ-008 addr0 / addr1  input  ADDR_W  byte address.
REQ-009 wdata0 / wdata1  input  DATA_W  write data.
REQ-010 gnt0 / gnt1  output  1  the access was issued to memory this cycle.
REQ-011 rvalid0 / rvalid1  output  1  read data is valid this cycle.
REQ-012 rdata0 / rdata1  output  DATA_W  read data.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, synchronous, valid one cycle after mem_en with mem_we = 0.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, OWN0 and OWN1.
REQ-019 gnt_x SHALL equal (state==OWNx && req_x), computed combinationally; at most one gnt SHALL be high in any cycle.
REQ-020 mem_en SHALL equal gnt0|gnt1, and mem_we/addr/wdata SHALL be muxed from the granted port; when there is no grant, mem_en and mem_we SHALL be 0 and mem_addr and mem_wdata SHALL be 0.
REQ-021 In IDLE with any request, the FSM SHALL move to OWNx of the selected port, so the first grant comes 1 cycle after req rises.
REQ-022 When both ports request in IDLE, the selected port SHALL be chosen per REQ-034 and REQ-035.
REQ-023 A beat counter SHALL clear on entry to OWNx and increment on each gnt_x.
REQ-024 In OWNx with req_x low, the FSM SHALL go to OWNy if req_y is high, else to IDLE.
REQ-025 In OWNx when the counter reaches MAX_BURST-1 on a granted beat and req_y is high, the FSM SHALL go to OWNy (preemption, with no idle cycle between owners).
REQ-026 In OWNx when the counter reaches MAX_BURST-1 and req_y is low, the FSM SHALL stay in OWNx and the counter SHALL saturate at MAX_BURST-1.
REQ-027 A granted read SHALL assert rvalid_x for exactly 1 cycle, 1 cycle after gnt_x, with rdata_x = mem_rdata.
REQ-028 rdata_x SHALL be 0 when rvalid_x is low.
REQ-029 A granted write SHALL produce no rvalid.
REQ-030 A requester SHALL hold req, we, addr and wdata stable until it sees gnt.
REQ-031 The arbiter SHALL NOT drop a request and SHALL NOT re-issue a granted beat unless req is held for another beat.
REQ-032 last_owner SHALL record the port of the most recent grant.

Reset
REQ-033 While rst_n=1, and from the assertion edge onward: state=IDLE, counter=0, last_owner=1 (port 0 wins first), gnt0/1=0, rvalid0/1=0, mem_en=0, mem_we=0; a read in flight at reset assertion SHALL produce no rvalid.

Configuration
REQ-034 With ARB_RR_EN defined: both-request ties in IDLE SHALL go to the port that is not last_owner, and the MAX_BURST preemption SHALL apply to both owners.
REQ-035 With ARB_RR_EN undefined: fixed priority SHALL apply, port 0 winning all ties; port 1 SHALL be preempted after MAX_BURST beats when req0 is high; port 0 SHALL never be preempted.

Verification
REQ-036 Port-0 read, addr0=0x10, mem_rdata=0xDEADBEEF -> gnt0 in cycle 1, rvalid0=1 with rdata0=0xDEADBEEF in cycle 2, and no activity on port 1.
REQ-037 Both ports request continuously with MAX_BURST=8, ARB_RR_EN defined -> 8 gnt0 beats, then 8 gnt1 beats, alternating, with no idle cycle at handover.
REQ-038 Same stimulus as REQ-037 with ARB_RR_EN undefined -> gnt0 every cycle and gnt1 never.
REQ-039 Port 1 writes 0x00000055 to 0x40 for 3 beats, then drops req1 -> 3 mem_we pulses, then state IDLE, with no rvalid1.
REQ-040 rst_n asserted the cycle after a granted port-0 read -> rvalid0 stays 0, all outputs 0, and after release the first tie is granted to port 0.
